// File: rtl/fa_bist_ctrl.sv
// Full-adder BIST sequencer: walks {A,B,C} through 000..111 and compares Y1/Y2 against sum/carry.
// done pulses 8*(SETTLE_CYCLES+1) cycles after an accepted start; start is ignored while busy.
module fa_bist_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       Y1,
  input  logic       Y2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [3:0] r_settle;
  logic [3:0] w_settle_nxt;
  logic [3:0] r_err;
  logic [3:0] w_err_nxt;
  logic [3:0] w_err_upd;
  logic [7:0] r_fail;
  logic [7:0] w_fail_nxt;
  logic       r_pass;
  logic       w_pass_nxt;
  logic       w_exp_sum;
  logic       w_exp_cry;
  logic       w_mis;

  assign w_exp_sum = r_idx[2] ^ r_idx[1] ^ r_idx[0];
  assign w_exp_cry = (r_idx[2] & r_idx[1]) | (r_idx[2] & r_idx[0]) | (r_idx[1] & r_idx[0]);

  // Case items match exactly, so an X or Z response falls through to the mismatch default.
  always_comb begin
    w_mis = 1'b1;
    case ({Y1, Y2})
      {w_exp_sum, w_exp_cry}: w_mis = 1'b0;
      default:                w_mis = 1'b1;
    endcase
  end

  assign w_err_upd = r_err + {3'b000, w_mis};

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_settle_nxt = r_settle;
    w_err_nxt    = r_err;
    w_fail_nxt   = r_fail;
    w_pass_nxt   = r_pass;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_nxt    = 3'd0;
          w_settle_nxt = 4'd0;
          w_err_nxt    = 4'd0;
          w_fail_nxt   = 8'h00;
          w_pass_nxt   = 1'b0;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_settle == SETTLE_LAST) begin
          w_settle_nxt = 4'd0;
          w_state_nxt  = S_CHECK;
        end else begin
          w_settle_nxt = r_settle + 4'd1;
        end
      end
      S_CHECK: begin
        w_err_nxt  = w_err_upd;
        w_fail_nxt = r_fail | (8'(w_mis) << r_idx);
        if (r_idx == 3'd7) begin
          // Verdict is taken from the count including this final vector.
          w_pass_nxt  = (w_err_upd == 4'd0);
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 3'd1;
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 3'd0;
      r_settle <= 4'd0;
      r_err    <= 4'd0;
      r_fail   <= 8'h00;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_settle <= w_settle_nxt;
      r_err    <= w_err_nxt;
      r_fail   <= w_fail_nxt;
      r_pass   <= w_pass_nxt;
    end
  end

  assign A        = r_idx[2];
  assign B        = r_idx[1];
  assign C        = r_idx[0];
  assign busy     = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done     = (r_state == S_DONE);
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_vec = r_fail;

endmodule
